keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Row-strobing matrix keypad scanner with press/release debounce.
// Emits one key_valid pulse per confirmed press; key_held spans press to release.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      column,
    output logic [ROWS-1:0] row,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic            key_held
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        DRIVE,
        SAMPLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t          state, state_next;
    logic [2:0]      col_meta, sample;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   row_idx, row_idx_next;
    logic [2:0]      pattern;
    logic [1:0]      col_idx, col_sel;
    logic [ROWS-1:0] row_next;
    logic [3:0]      code_next;
    logic            one_low;
    logic            cnt_clear, cnt_one, cnt_inc;
    logic            advance, capture, fire, drop;

    assign one_low = (sample == 3'b110) || (sample == 3'b101) || (sample == 3'b011);

    always_ff @(posedge clk) begin
        if (reset) state <= DRIVE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_one    = 1'b0;
        cnt_inc    = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        fire       = 1'b0;
        drop       = 1'b0;
        case (state)
            DRIVE: begin
                if (cnt >= CW'(SETTLE_CYCLES - 1)) begin
                    state_next = SAMPLE;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SAMPLE: begin
                if (one_low) begin
                    state_next = DEBOUNCE;
                    capture    = 1'b1;
                    cnt_one    = 1'b1;
                end else begin
                    state_next = DRIVE;
                    advance    = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (sample == pattern) begin
                    if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_next = PRESSED;
                        fire       = 1'b1;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    state_next = DRIVE;
                    advance    = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            PRESSED: begin
                if (sample == 3'b111) begin
                    state_next = RELEASE;
                    cnt_one    = 1'b1;
                end
            end
            RELEASE: begin
                if (sample == 3'b111) begin
                    if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_next = DRIVE;
                        drop       = 1'b1;
                        advance    = 1'b1;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    // release bounce: fall back without re-reporting
                    state_next = PRESSED;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                state_next = DRIVE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    always_comb begin
        row_idx_next = row_idx;
        if (advance)
            row_idx_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
        row_next = ~(ROWS'(1) << row_idx_next);
        case (sample)
            3'b110:  col_sel = 2'd0;
            3'b101:  col_sel = 2'd1;
            default: col_sel = 2'd2;
        endcase
        code_next = 4'(int'(row_idx) * 3 + int'(col_idx));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta  <= '1;
            sample    <= '1;
            row       <= '1;
            row_idx   <= '0;
            cnt       <= '0;
            pattern   <= '1;
            col_idx   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            col_meta  <= column;
            sample    <= col_meta;
            row       <= row_next;
            row_idx   <= row_idx_next;
            key_valid <= fire;
            if (cnt_clear)
                cnt <= '0;
            else if (cnt_one)
                cnt <= CW'(1);
            else if (cnt_inc && (cnt != '1))
                cnt <= cnt + 1'b1;
            if (capture) begin
                pattern <= sample;
                col_idx <= col_sel;
            end
            if (fire) begin
                key_code <= code_next;
                key_held <= 1'b1;
            end else if (drop) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a key-code scoreboard
// filled when presses are driven and drained on each key_valid pulse.
module tb_keypad_scanner;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      column;
    logic [3:0]      row;
    logic            key_valid;
    logic [3:0]      key_code;
    logic            key_held;
    logic [3:0][2:0] keys = '0;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_exp;
    logic prev_kv = 1'b0;

    keypad_scanner #(
        .ROWS(4),
        .SETTLE_CYCLES(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .column(column),
        .row(row),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        column = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r][c] && !row[r]) column[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_key_valid: code=%0d, required no pulse", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== 4'(mon_exp)) begin
                    bad++;
                    $display("FAIL key_code_scoreboard: got %0d, required %0d", key_code, mon_exp);
                end
            end
            if (prev_kv === 1'b1) begin
                total++;
                bad++;
                $display("FAIL key_valid_double: high two cycles in a row, required single pulse");
            end
        end
        prev_kv = key_valid;
    end

    task automatic wait_held(input logic v, input int max_cyc, input string name);
        int n = 0;
        while (key_held !== v && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (key_held !== v) begin
            bad++;
            $display("FAIL %s: key_held=%b after %0d cycles, required %b", name, key_held, n, v);
        end
    endtask

    task automatic test_reset;
        logic [3:0] rec[30];
        logic [3:0] vals[$];
        int lens[$];
        logic [3:0] exp_seq[5];
        exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1101; exp_seq[2] = 4'b1011;
        exp_seq[3] = 4'b0111; exp_seq[4] = 4'b1110;
        reset = 1'b1;
        keys  = '0;
        repeat (3) @(negedge clk);
        total++;
        if (row !== 4'b1111) begin
            bad++;
            $display("FAIL reset_row: got %b, required 1111", row);
        end
        total++;
        if ({key_valid, key_code, key_held} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b code=%0d held=%b, required 0/0/0",
                     key_valid, key_code, key_held);
        end
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rec[i] = row;
        end
        for (int i = 0; i < 30; i++) begin
            if (i == 0 || rec[i] !== rec[i-1]) begin
                vals.push_back(rec[i]);
                lens.push_back(1);
            end else begin
                lens[lens.size()-1]++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (vals.size() <= k || vals[k] !== exp_seq[k]) begin
                bad++;
                $display("FAIL scan_order[%0d]: got %b, required %b", k,
                         (vals.size() > k) ? vals[k] : 4'bxxxx, exp_seq[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            total++;
            if (lens.size() <= k || lens[k] != 5) begin
                bad++;
                $display("FAIL scan_period[%0d]: got %0d clocks, required 5", k,
                         (lens.size() > k) ? lens[k] : -1);
            end
        end
    endtask

    task automatic test_clean_press;
        int errs = 0;
        exp_q.push_back(7);
        keys[2][1] = 1'b1;
        wait_held(1'b1, 200, "clean_press_detect");
        total++;
        if (key_code !== 4'd7 || row !== 4'b1011) begin
            bad++;
            $display("FAIL clean_press_code_row: code=%0d row=%b, required 7/1011", key_code, row);
        end
        repeat (40) begin
            @(negedge clk);
            if (row !== 4'b1011 || key_held !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL clean_press_hold: %0d bad cycles, required 0", errs);
        end
        keys[2][1] = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (key_held !== 1'b1) begin
            bad++;
            $display("FAIL clean_release_early: key_held=%b, required 1", key_held);
        end
        @(negedge clk);
        total++;
        if (key_held !== 1'b0 || row !== 4'b0111) begin
            bad++;
            $display("FAIL clean_release: held=%b row=%b, required 0/0111", key_held, row);
        end
    endtask

    task automatic test_press_bounce;
        int held_errs = 0;
        int changes = 0;
        logic [3:0] last;
        last = row;
        for (int i = 0; i < 150; i++) begin
            keys[0][2] = ((i % 3) != 2);
            @(negedge clk);
            if (key_held !== 1'b0) held_errs++;
            if (row !== last) changes++;
            last = row;
        end
        keys = '0;
        total++;
        if (held_errs != 0) begin
            bad++;
            $display("FAIL press_bounce_held: %0d cycles held, required 0", held_errs);
        end
        total++;
        if (changes < 20) begin
            bad++;
            $display("FAIL press_bounce_scan: %0d row changes, required >= 20", changes);
        end
        repeat (10) @(negedge clk);
        exp_q.push_back(2);
        keys[0][2] = 1'b1;
        wait_held(1'b1, 200, "bounce_stable_detect");
        total++;
        if (key_code !== 4'd2) begin
            bad++;
            $display("FAIL bounce_stable_code: got %0d, required 2", key_code);
        end
        keys = '0;
        wait_held(1'b0, 50, "bounce_stable_release");
    endtask

    task automatic test_release_bounce;
        int errs = 0;
        exp_q.push_back(3);
        keys[1][0] = 1'b1;
        wait_held(1'b1, 200, "release_bounce_detect");
        repeat (10) @(negedge clk);
        keys[1][0] = 1'b0;
        repeat (2) begin @(negedge clk); if (key_held !== 1'b1) errs++; end
        keys[1][0] = 1'b1;
        repeat (3) begin @(negedge clk); if (key_held !== 1'b1) errs++; end
        keys[1][0] = 1'b0;
        repeat (5) begin @(negedge clk); if (key_held !== 1'b1) errs++; end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL release_bounce_held: %0d cycles dropped, required 0", errs);
        end
        wait_held(1'b0, 20, "release_bounce_final");
        total++;
        if (key_code !== 4'd3) begin
            bad++;
            $display("FAIL release_bounce_code: got %0d, required 3", key_code);
        end
    endtask

    task automatic test_multi_key;
        int errs = 0;
        int row3 = 0;
        keys[3][0] = 1'b1;
        keys[3][2] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (key_held !== 1'b0) errs++;
            if (row === 4'b0111) row3++;
        end
        total++;
        if (errs != 0 || row3 == 0) begin
            bad++;
            $display("FAIL multi_key: held %0d cycles, row3 %0d cycles, required 0 and >0", errs, row3);
        end
        exp_q.push_back(9);
        keys[3][2] = 1'b0;
        wait_held(1'b1, 200, "multi_single_detect");
        total++;
        if (key_code !== 4'd9) begin
            bad++;
            $display("FAIL multi_single_code: got %0d, required 9", key_code);
        end
        keys = '0;
        wait_held(1'b0, 50, "multi_single_release");
    endtask

    task automatic test_reset_pressed;
        exp_q.push_back(8);
        keys[2][2] = 1'b1;
        wait_held(1'b1, 200, "reset_pressed_detect");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (key_held !== 1'b0 || row !== 4'b1111 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_pressed: held=%b row=%b valid=%b, required 0/1111/0",
                     key_held, row, key_valid);
        end
        @(negedge clk);
        exp_q.push_back(8);
        reset = 1'b0;
        wait_held(1'b1, 200, "reset_redetect");
        total++;
        if (key_code !== 4'd8) begin
            bad++;
            $display("FAIL reset_redetect_code: got %0d, required 8", key_code);
        end
        keys = '0;
        wait_held(1'b0, 50, "reset_redetect_release");
        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected pulses missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_press_bounce;
        test_release_bounce;
        test_multi_key;
        test_reset_pressed;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
